// File: rtl/mem_stage_if.sv
// Execute-to-memory bundle: upstream request/result fields, the data-memory port and the write-back outputs.
// addr_error exists only when MEM_STAGE_ALIGN_CHECK_EN is defined.
interface mem_stage_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              is_mem;
   logic              is_int_wb;
   logic              load_unsigned;
   logic [1:0]        data_width;
   logic [ADDR_W-1:0] effective_address;
   logic [31:0]       value_to_be_store;
   logic [5:0]        int_wb_address;
   logic [31:0]       int_wb_value;
   logic              mem_busy;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [3:0]        dmem_be;
   logic [31:0]       dmem_wdata;
   logic              dmem_ready;
   logic [31:0]       dmem_rdata;
   logic              wb_valid;
   logic [5:0]        wb_address;
   logic [31:0]       wb_value;
   logic              mem_done;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
   logic              addr_error;
`endif

   modport master (
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      input  addr_error,
`endif
      output in_valid, is_mem, is_int_wb, load_unsigned, data_width,
      output effective_address, value_to_be_store, int_wb_address, int_wb_value,
      output dmem_ready, dmem_rdata,
      input  mem_busy, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  wb_valid, wb_address, wb_value, mem_done
   );

   modport slave (
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      output addr_error,
`endif
      input  in_valid, is_mem, is_int_wb, load_unsigned, data_width,
      input  effective_address, value_to_be_store, int_wb_address, int_wb_value,
      input  dmem_ready, dmem_rdata,
      output mem_busy, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output wb_valid, wb_address, wb_value, mem_done
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: pass-through in 1 cycle, loads/stores held on dmem until dmem_ready; mem_busy stalls upstream.
// MEM_STAGE_ALIGN_CHECK_EN rejects misaligned half/word accesses with an addr_error pulse instead of forcing alignment.
module mem_stage #(
   parameter int ADDR_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   mem_stage_if.slave  bus
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        width_q, width_d;
   logic [1:0]        off_q, off_d;
   logic              uns_q, uns_d;
   logic [5:0]        dst_q, dst_d;
   logic              wb_valid_q, wb_valid_d;
   logic [5:0]        wb_addr_q, wb_addr_d;
   logic [31:0]       wb_value_q, wb_value_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [1:0]        in_off;
   logic [3:0]        in_be;
   logic [31:0]       in_wdata;
   logic              in_misaligned;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_value;

   assign in_off = bus.effective_address[1:0];

   // Big-endian lanes: offset 0 lives in bits [31:24]; width 11 behaves as word.
   always_comb begin
      in_be         = 4'b1111;
      in_wdata      = bus.value_to_be_store;
      in_misaligned = 1'b0;
      case (bus.data_width)
         2'b00: begin
            in_be    = 4'b1000 >> in_off;
            in_wdata = {4{bus.value_to_be_store[7:0]}};
         end
         2'b01: begin
            in_be         = in_off[1] ? 4'b0011 : 4'b1100;
            in_wdata      = {2{bus.value_to_be_store[15:0]}};
            in_misaligned = in_off[0];
         end
         default: in_misaligned = (in_off != 2'b00);
      endcase
   end

   always_comb begin
      case (off_q)
         2'd0:    ld_byte = bus.dmem_rdata[31:24];
         2'd1:    ld_byte = bus.dmem_rdata[23:16];
         2'd2:    ld_byte = bus.dmem_rdata[15:8];
         default: ld_byte = bus.dmem_rdata[7:0];
      endcase
      ld_half = off_q[1] ? bus.dmem_rdata[15:0] : bus.dmem_rdata[31:16];
      case (width_q)
         2'b00:   ld_value = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_value = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_value = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      width_d    = width_q;
      off_d      = off_q;
      uns_d      = uns_q;
      dst_d      = dst_q;
      wb_valid_d = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_value_d = wb_value_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (!bus.is_mem) begin
                  wb_valid_d = bus.is_int_wb;
                  wb_addr_d  = bus.int_wb_address;
                  wb_value_d = bus.int_wb_value;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
               end else if (in_misaligned) begin
                  err_d = 1'b1;
`endif
               end else begin
                  state_d = ACCESS;
                  we_d    = !bus.is_int_wb;
                  addr_d  = {bus.effective_address[ADDR_W-1:2], 2'b00};
                  be_d    = in_be;
                  wdata_d = in_wdata;
                  width_d = bus.data_width;
                  off_d   = in_off;
                  uns_d   = bus.load_unsigned;
                  dst_d   = bus.int_wb_address;
               end
            end
         end
         ACCESS: begin
            if (bus.dmem_ready) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (!we_q) begin
                  wb_valid_d = 1'b1;
                  wb_addr_d  = dst_q;
                  wb_value_d = ld_value;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= 4'd0;
         wdata_q    <= 32'd0;
         width_q    <= 2'd0;
         off_q      <= 2'd0;
         uns_q      <= 1'b0;
         dst_q      <= 6'd0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= 6'd0;
         wb_value_q <= 32'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         width_q    <= width_d;
         off_q      <= off_d;
         uns_q      <= uns_d;
         dst_q      <= dst_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_value_q <= wb_value_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.mem_busy   = (state_q == ACCESS);
   assign bus.dmem_req   = (state_q == ACCESS);
   assign bus.dmem_we    = we_q;
   assign bus.dmem_addr  = addr_q;
   assign bus.dmem_be    = be_q;
   assign bus.dmem_wdata = wdata_q;
   assign bus.wb_valid   = wb_valid_q;
   assign bus.wb_address = wb_addr_q;
   assign bus.wb_value   = wb_value_q;
   assign bus.mem_done   = done_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
   assign bus.addr_error = err_q;
`else
   logic unused_err;
   assign unused_err = err_q ^ in_misaligned ^ err_d;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a lane/extension model built from byte-offset arithmetic.
module tb_mem_stage;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   mem_stage_if #(.ADDR_W(32)) bus ();
   mem_stage #(.ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] m_be(input logic [1:0] w, input int off);
      if (w == 2'b00) return 32'(1 << (3 - off));
      if (w == 2'b01) return (off / 2 == 1) ? 32'h3 : 32'hC;
      return 32'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
      if (w == 2'b00) return (d & 32'hFF) * 32'h01010101;
      if (w == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] w, input int off, input bit uns,
                                          input logic [31:0] rd);
      logic [31:0] v;
      if (w == 2'b00) begin
         v = (rd >> (8 * (3 - off))) & 32'hFF;
         if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (w == 2'b01) begin
         v = (rd >> ((off / 2 == 1) ? 0 : 16)) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   task automatic idle_inputs();
      bus.in_valid = 0; bus.is_mem = 0; bus.is_int_wb = 0; bus.load_unsigned = 0;
      bus.data_width = 0; bus.effective_address = 0; bus.value_to_be_store = 0;
      bus.int_wb_address = 0; bus.int_wb_value = 0; bus.dmem_ready = 0; bus.dmem_rdata = 0;
   endtask

   task automatic do_op(input bit mem, input bit iwb, input bit uns, input logic [1:0] w,
                        input logic [31:0] ea, input logic [31:0] sd, input logic [5:0] dst,
                        input logic [31:0] alu, input logic [31:0] rd, input int waits,
                        input bit junk);
      int          off;
      logic [31:0] e_be, e_wd;
      bit          mis;
      off  = int'(ea % 4);
      mis  = (w == 2'b01 && (off % 2) != 0) || (w[1] && off != 0);
      e_be = m_be(w, off);
      e_wd = m_wdata(w, sd);
      bus.in_valid = 1; bus.is_mem = mem; bus.is_int_wb = iwb; bus.load_unsigned = uns;
      bus.data_width = w; bus.effective_address = ea; bus.value_to_be_store = sd;
      bus.int_wb_address = dst; bus.int_wb_value = alu;
      step();
      bus.in_valid = 0;
      if (!mem) begin
         chk("pt_wb_valid", bus.wb_valid, iwb);
         if (iwb) begin
            chk("pt_wb_address", bus.wb_address, dst);
            chk("pt_wb_value", bus.wb_value, alu);
         end
         chk("pt_dmem_req", bus.dmem_req, 0);
         chk("pt_mem_busy", bus.mem_busy, 0);
         return;
      end
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      if (mis) begin
         chk("al_addr_error", bus.addr_error, 1);
         chk("al_dmem_req", bus.dmem_req, 0);
         chk("al_mem_busy", bus.mem_busy, 0);
         chk("al_wb_valid", bus.wb_valid, 0);
         chk("al_mem_done", bus.mem_done, 0);
         step();
         chk("al_addr_error_pulse", bus.addr_error, 0);
         return;
      end
`endif
      chk("req_dmem_req", bus.dmem_req, 1);
      chk("req_mem_busy", bus.mem_busy, 1);
      chk("req_dmem_we", bus.dmem_we, !iwb);
      chk("req_dmem_addr", bus.dmem_addr, ea & 32'hFFFFFFFC);
      chk("req_dmem_be", bus.dmem_be, e_be);
      if (!iwb) chk("req_dmem_wdata", bus.dmem_wdata, e_wd);
      if (junk) begin
         bus.in_valid = 1; bus.is_mem = 0; bus.is_int_wb = 1;
         bus.int_wb_value = $urandom;
      end
      for (int i = 0; i < waits; i++) begin
         step();
         chk("wait_dmem_req", bus.dmem_req, 1);
         chk("wait_dmem_be", bus.dmem_be, e_be);
         chk("wait_dmem_addr", bus.dmem_addr, ea & 32'hFFFFFFFC);
         chk("wait_wb_valid", bus.wb_valid, 0);
         chk("wait_mem_done", bus.mem_done, 0);
      end
      bus.dmem_ready = 1; bus.dmem_rdata = rd;
      step();
      bus.dmem_ready = 0;
      bus.in_valid = 0;
      chk("cmp_mem_done", bus.mem_done, 1);
      chk("cmp_wb_valid", bus.wb_valid, iwb);
      if (iwb) begin
         chk("cmp_wb_address", bus.wb_address, dst);
         chk("cmp_wb_value", bus.wb_value, m_load(w, off, uns, rd));
      end
      chk("cmp_dmem_req", bus.dmem_req, 0);
      chk("cmp_mem_busy", bus.mem_busy, 0);
      bus.dmem_ready = 1'($urandom);
      step();
      bus.dmem_ready = 0;
      chk("post_mem_done", bus.mem_done, 0);
      chk("post_wb_valid", bus.wb_valid, 0);
      chk("post_dmem_req", bus.dmem_req, 0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      reset = 1;
      step();
      step();
      chk("rst_dmem_req", bus.dmem_req, 0);
      chk("rst_mem_busy", bus.mem_busy, 0);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_mem_done", bus.mem_done, 0);
      chk("rst_dmem_be", bus.dmem_be, 0);
      chk("rst_wb_value", bus.wb_value, 0);
      reset = 0;

      do_op(0, 1, 0, 2'b10, 32'h0, 32'h0, 6'd9, 32'h1234, 32'h0, 0, 0);
      do_op(0, 1, 0, 2'b10, 32'h0, 32'h0, 6'd10, 32'h5678, 32'h0, 0, 0);
      do_op(0, 0, 0, 2'b10, 32'h0, 32'h0, 6'd11, 32'h9ABC, 32'h0, 0, 0);
      do_op(1, 1, 0, 2'b00, 32'h103, 32'h0, 6'd5, 32'h0, 32'h112233F0, 3, 0);
      do_op(1, 1, 1, 2'b00, 32'h103, 32'h0, 6'd5, 32'h0, 32'h112233F0, 3, 0);
      do_op(1, 0, 0, 2'b01, 32'h202, 32'hABCD1234, 6'd0, 32'h0, 32'h0, 0, 0);
      do_op(1, 1, 0, 2'b01, 32'h300, 32'h0, 6'd7, 32'h0, 32'h8001_7FFF, 2, 1);
      do_op(1, 1, 0, 2'b10, 32'h101, 32'h0, 6'd8, 32'h0, 32'hDEADBEEF, 1, 0);

      // Reset two cycles into a word load; the late response must be dropped.
      bus.in_valid = 1; bus.is_mem = 1; bus.is_int_wb = 1; bus.data_width = 2'b10;
      bus.effective_address = 32'h400; bus.int_wb_address = 6'd3;
      step();
      bus.in_valid = 0;
      step();
      reset = 1;
      step();
      reset = 0;
      chk("rma_dmem_req", bus.dmem_req, 0);
      chk("rma_mem_busy", bus.mem_busy, 0);
      chk("rma_dmem_addr", bus.dmem_addr, 0);
      chk("rma_dmem_be", bus.dmem_be, 0);
      chk("rma_wb_valid", bus.wb_valid, 0);
      chk("rma_mem_done", bus.mem_done, 0);
      bus.dmem_ready = 1; bus.dmem_rdata = 32'hCAFEF00D;
      step();
      bus.dmem_ready = 0;
      chk("rma_late_wb_valid", bus.wb_valid, 0);
      chk("rma_late_mem_done", bus.mem_done, 0);
      chk("rma_late_dmem_req", bus.dmem_req, 0);

      for (int n = 0; n < 80; n++) begin
         do_op(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
               $urandom, $urandom, 6'($urandom), $urandom, $urandom,
               int'($urandom_range(0, 4)), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
